// File: rtl/icache_fill_ctrl.sv
// Instruction-fetch miss controller: cache lookup, single-word refill from the bus, response to core.
// Optional performance counters are compiled in with `define ICACHE_PERF_EN.
module icache_fill_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic [ADDR_W-1:0] cache_addr,
    input  logic              cache_hit,
    input  logic [DATA_W-1:0] cache_rdata,
    output logic              fill_wen,
    output logic [DATA_W-1:0] fill_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    input  logic              mem_resp_err,
`ifdef ICACHE_PERF_EN
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic [CNT_W-1:0]  err_count,
`endif
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOKUP   = 3'd1,
        S_MEM_REQ  = 3'd2,
        S_MEM_WAIT = 3'd3,
        S_FILL     = 3'd4,
        S_RESP     = 3'd5
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;

    assign cache_addr = addr_q;
    assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign state_dbg  = state;

    // Handshakes: a transfer happens on a rising edge where valid && ready; a valid
    // side holds its payload stable until that edge and never drops valid before it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            addr_q        <= '0;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            resp_err      <= 1'b0;
            fill_wen      <= 1'b0;
            fill_data     <= '0;
            mem_req_valid <= 1'b0;
        end else begin
            fill_wen <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q    <= req_addr;
                        req_ready <= 1'b0;
                        if (req_addr[1:0] != 2'b00) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= '0;
                            state      <= S_RESP;
                        end else begin
                            state <= S_LOOKUP;
                        end
                    end
                end
                S_LOOKUP: begin
                    if (cache_hit) begin
                        resp_data  <= cache_rdata;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        mem_req_valid <= 1'b1;
                        state         <= S_MEM_REQ;
                    end
                end
                S_MEM_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= S_MEM_WAIT;
                    end
                end
                S_MEM_WAIT: begin
                    // Bus responses are only looked at here, so a reset abort drops any late one.
                    if (mem_resp_valid) begin
                        if (mem_resp_err) begin
                            resp_err   <= 1'b1;
                            resp_data  <= '0;
                            resp_valid <= 1'b1;
                            state      <= S_RESP;
                        end else begin
                            fill_data <= mem_resp_data;
                            fill_wen  <= 1'b1;
                            state     <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    resp_data  <= fill_data;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    resp_valid    <= 1'b0;
                    resp_err      <= 1'b0;
                    mem_req_valid <= 1'b0;
                    req_ready     <= 1'b1;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ICACHE_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic err_entry;
    assign err_entry = (state == S_IDLE && req_valid && req_ready && req_addr[1:0] != 2'b00) ||
                       (state == S_MEM_WAIT && mem_resp_valid && mem_resp_err);

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
            err_count  <= '0;
        end else begin
            if (state == S_LOOKUP && cache_hit && hit_count != '1)
                hit_count <= hit_count + CNT_ONE;
            if (state == S_LOOKUP && !cache_hit && miss_count != '1)
                miss_count <= miss_count + CNT_ONE;
            if (err_entry && err_count != '1)
                err_count <= err_count + CNT_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl: hit/miss/fill, misaligned, bus error, backpressure, reset abort.
// Counter checks are compiled in with `define ICACHE_PERF_EN.
module tb_icache_fill_ctrl;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 32;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_MEM_WAIT = 3'd3;

    logic              clock;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;
    logic [ADDR_W-1:0] cache_addr;
    logic              cache_hit;
    logic [DATA_W-1:0] cache_rdata;
    logic              fill_wen;
    logic [DATA_W-1:0] fill_data;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;
    logic              mem_resp_err;
    logic [2:0]        state_dbg;
`ifdef ICACHE_PERF_EN
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;
    logic [CNT_W-1:0]  err_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] exp_q[$];

    // monitor: fill strobes and memory-request cycles seen outside reset
    int                fill_cnt   = 0;
    int                memreq_cnt = 0;
    logic [DATA_W-1:0] fill_data_seen = '0;
    logic [ADDR_W-1:0] fill_addr_seen = '0;

    icache_fill_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_err       (resp_err),
        .cache_addr     (cache_addr),
        .cache_hit      (cache_hit),
        .cache_rdata    (cache_rdata),
        .fill_wen       (fill_wen),
        .fill_data      (fill_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_err   (mem_resp_err),
`ifdef ICACHE_PERF_EN
        .hit_count      (hit_count),
        .miss_count     (miss_count),
        .err_count      (err_count),
`endif
        .state_dbg      (state_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset) begin
            if (fill_wen) begin
                fill_cnt       <= fill_cnt + 1;
                fill_data_seen <= fill_data;
                fill_addr_seen <= cache_addr;
            end
            if (mem_req_valid) memreq_cnt <= memreq_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic send_req(input logic [ADDR_W-1:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (resp_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    task automatic run_txn(input logic [ADDR_W-1:0] a, input logic hit,
                           input logic [DATA_W-1:0] d, output bit ok);
        cache_hit      = hit;
        cache_rdata    = d;
        mem_req_ready  = 1'b1;
        mem_resp_valid = !hit;
        mem_resp_data  = d;
        mem_resp_err   = 1'b0;
        send_req(a);
        wait_resp(20, ok);
        consume();
        mem_resp_valid = 1'b0;
        cache_hit      = 1'b0;
    endtask

    // tests
    task automatic test_reset();
        do_reset();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
        n_checks++; if (fill_wen !== 1'b0) begin n_fail++; $display("FAIL reset_fill_wen: got %b want 0", fill_wen); end
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req_valid: got %b want 0", mem_req_valid); end
        n_checks++; if (cache_addr !== 32'h0) begin n_fail++; $display("FAIL reset_cache_addr: got %h want 0", cache_addr); end
        n_checks++; if (resp_data !== 32'h0) begin n_fail++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
        n_checks++; if (fill_data !== 32'h0) begin n_fail++; $display("FAIL reset_fill_data: got %h want 0", fill_data); end
        n_checks++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE); end
    endtask

    task automatic test_miss_then_hit();
        int f0, m0;
        logic [DATA_W-1:0] exp;
        bit ok;
        f0 = fill_cnt; m0 = memreq_cnt;
        cache_hit = 1'b0; mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
        exp_q.push_back(32'h0000_0013);
        send_req(32'h0000_1000);
        step();
        n_checks++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL miss_mem_req_valid: got %b want 1", mem_req_valid); end
        n_checks++; if (mem_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL miss_mem_addr: got %h want 00001000", mem_addr); end
        step();
        step();
        step();
        mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0013;
        step();
        mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        n_checks++; if (fill_wen !== 1'b1 || fill_data !== 32'h13 || cache_addr !== 32'h1000) begin
            n_fail++; $display("FAIL miss_fill: got wen=%b data=%h addr=%h want 1/00000013/00001000", fill_wen, fill_data, cache_addr);
        end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL miss_resp_early: got %b want 0", resp_valid); end
        step();
        n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL miss_latency: resp_valid got %b want 1", resp_valid); end
        exp = exp_q.pop_front();
        n_checks++; if (resp_data !== exp || resp_err !== 1'b0) begin
            n_fail++; $display("FAIL miss_resp: got data=%h err=%b want %h/0", resp_data, resp_err, exp);
        end
        consume();
        n_checks++; if (fill_cnt - f0 !== 1) begin n_fail++; $display("FAIL miss_fill_pulses: got %0d want 1", fill_cnt - f0); end
        n_checks++; if (fill_data_seen !== 32'h13 || fill_addr_seen !== 32'h1000) begin
            n_fail++; $display("FAIL miss_fill_seen: got %h@%h want 00000013@00001000", fill_data_seen, fill_addr_seen);
        end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL miss_back_idle: req_ready got %b want 1", req_ready); end
        // re-request now hits
        m0 = memreq_cnt;
        exp_q.push_back(32'h0000_0013);
        send_req(32'h0000_1000);
        cache_hit = 1'b1; cache_rdata = 32'h0000_0013;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL hit_resp_early: got %b want 0", resp_valid); end
        step();
        cache_hit = 1'b0; cache_rdata = 32'h0;
        n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL hit_latency: resp_valid got %b want 1", resp_valid); end
        exp = exp_q.pop_front();
        n_checks++; if (resp_data !== exp || resp_err !== 1'b0) begin
            n_fail++; $display("FAIL hit_resp: got data=%h err=%b want %h/0", resp_data, resp_err, exp);
        end
        consume();
        n_checks++; if (memreq_cnt - m0 !== 0) begin n_fail++; $display("FAIL hit_no_mem: mem_req cycles got %0d want 0", memreq_cnt - m0); end
        wait_resp(1, ok);
        n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL hit_single_resp: resp_valid got 1 want 0"); end
    endtask

    task automatic test_misaligned();
        int f0, m0;
        f0 = fill_cnt; m0 = memreq_cnt;
        cache_hit = 1'b1; cache_rdata = 32'hCAFE_F00D;
        send_req(32'h0000_1002);
        cache_hit = 1'b0;
        n_checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== 32'h0) begin
            n_fail++; $display("FAIL misaligned_resp: got v=%b err=%b data=%h want 1/1/00000000", resp_valid, resp_err, resp_data);
        end
        consume();
        n_checks++; if (memreq_cnt - m0 !== 0 || fill_cnt - f0 !== 0) begin
            n_fail++; $display("FAIL misaligned_side_effects: got memreq=%0d fill=%0d want 0/0", memreq_cnt - m0, fill_cnt - f0);
        end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL misaligned_idle: req_ready got %b want 1", req_ready); end
    endtask

    task automatic test_bus_error();
        int f0;
        f0 = fill_cnt;
        cache_hit = 1'b0; mem_req_ready = 1'b1;
        send_req(32'h0000_2000);
        step();
        step();
        mem_resp_valid = 1'b1; mem_resp_err = 1'b1; mem_resp_data = 32'hFFFF_FFFF;
        step();
        mem_resp_valid = 1'b0; mem_resp_err = 1'b0; mem_resp_data = 32'h0;
        n_checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== 32'h0) begin
            n_fail++; $display("FAIL buserr_resp: got v=%b err=%b data=%h want 1/1/00000000", resp_valid, resp_err, resp_data);
        end
        consume();
        n_checks++; if (fill_cnt - f0 !== 0) begin n_fail++; $display("FAIL buserr_no_fill: got %0d want 0", fill_cnt - f0); end
        n_checks++; if (req_ready !== 1'b1 || state_dbg !== ST_IDLE) begin
            n_fail++; $display("FAIL buserr_idle: got ready=%b state=%0d want 1/0", req_ready, state_dbg);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        cache_hit = 1'b0; mem_req_ready = 1'b0;
        send_req(32'h0000_3004);
        step();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_req_valid !== 1'b1 || mem_addr !== 32'h0000_3004) bad++;
            step();
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL mem_stall_stable: got %0d unstable cycles want 0", bad); end
        mem_req_ready = 1'b1;
        step();
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mem_req_drop: got %b want 0", mem_req_valid); end
        mem_resp_valid = 1'b1; mem_resp_data = 32'hA5A5_0001;
        step();
        mem_resp_valid = 1'b0;
        step();
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid !== 1'b1 || resp_data !== 32'hA5A5_0001 || resp_err !== 1'b0 || req_ready !== 1'b0) bad++;
            step();
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL resp_stall_stable: got %0d unstable cycles want 0", bad); end
        consume();
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL resp_release: got v=%b ready=%b want 0/1", resp_valid, req_ready);
        end
    endtask

    task automatic test_resp_ready_early();
        resp_ready = 1'b1;
        send_req(32'h0000_0040);
        cache_hit = 1'b1; cache_rdata = 32'h1234_5678;
        step();
        cache_hit = 1'b0;
        n_checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h1234_5678) begin
            n_fail++; $display("FAIL early_ready_resp: got v=%b data=%h want 1/12345678", resp_valid, resp_data);
        end
        step();
        resp_ready = 1'b0;
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL early_ready_done: got v=%b ready=%b want 0/1", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid_miss();
        int bad;
        cache_hit = 1'b0; mem_req_ready = 1'b1;
        send_req(32'h0000_4000);
        step();
        step();
        n_checks++; if (state_dbg !== ST_MEM_WAIT) begin n_fail++; $display("FAIL abort_in_wait: state got %0d want %0d", state_dbg, ST_MEM_WAIT); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            mem_resp_valid = 1'b0;
            if (fill_wen !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1 || state_dbg !== ST_IDLE) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL abort_idle: got %0d bad cycles want 0", bad); end
    endtask

`ifdef ICACHE_PERF_EN
    task automatic test_perf();
        bit ok;
        int bad;
        do_reset();
        n_checks++; if (hit_count !== 0 || miss_count !== 0 || err_count !== 0) begin
            n_fail++; $display("FAIL perf_reset: got %0d/%0d/%0d want 0/0/0", hit_count, miss_count, err_count);
        end
        bad = 0;
        run_txn(32'h0000_0100, 1'b1, 32'h11, ok); if (!ok) bad++;
        run_txn(32'h0000_0200, 1'b0, 32'h22, ok); if (!ok) bad++;
        run_txn(32'h0000_0104, 1'b1, 32'h33, ok); if (!ok) bad++;
        run_txn(32'h0000_0301, 1'b1, 32'h44, ok); if (!ok) bad++;
        run_txn(32'h0000_0400, 1'b0, 32'h55, ok); if (!ok) bad++;
        run_txn(32'h0000_0108, 1'b1, 32'h66, ok); if (!ok) bad++;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL perf_txn_timeout: got %0d timeouts want 0", bad); end
        n_checks++; if (hit_count !== 3) begin n_fail++; $display("FAIL perf_hits: got %0d want 3", hit_count); end
        n_checks++; if (miss_count !== 2) begin n_fail++; $display("FAIL perf_misses: got %0d want 2", miss_count); end
        n_checks++; if (err_count !== 1) begin n_fail++; $display("FAIL perf_errs: got %0d want 1", err_count); end
    endtask
`endif

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
        cache_hit = 1'b0; cache_rdata = '0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_err = 1'b0;
        test_reset();
        test_miss_then_hit();
        test_misaligned();
        test_bus_error();
        test_backpressure();
        test_resp_ready_early();
        test_reset_mid_miss();
`ifdef ICACHE_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
